irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Prioritising interrupt controller between the peripheral interrupt flags (VGA
//  blanking-start, timer top/match0/match1) and the CPU. Masks and arbitrates the
//  flags, presents one request plus vector to the CPU, and sequences the
//  one-cycle flag-clear pulse back to the winning peripheral. Configured by the
//  CPU through a small register file decoded from the data-memory/IO space.
// PARAMETERS
//  NUM_IRQ   4   number of interrupt sources, 2..8; source 0 = highest fixed priority
//  VEC_W     2   vector width, localparam = $clog2(NUM_IRQ)
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  reset         in   1        asynchronous, active-low reset
//  irq_flag      in   NUM_IRQ  sticky level flags from peripherals (held until cleared)
//  irq_flag_clr  out  NUM_IRQ  one-cycle clear pulse to the serviced peripheral
//  cpu_irq       out  1        interrupt request to CPU (registered)
//  cpu_vec       out  VEC_W    index of requesting source, valid while cpu_irq=1
//  cpu_ack       in   1        one-cycle pulse: CPU has taken the request
//  cpu_iret      in   1        one-cycle pulse: CPU has returned from the handler
//  cfg_we        in   1        register write strobe
//  cfg_addr      in   2        register select
//  cfg_wdata     in   8        write data
//  cfg_rdata     out  8        read data, combinational from cfg_addr
// BEHAVIOUR
//  Registers: 0 MASK[NUM_IRQ-1:0] rw, 1 PENDING = irq_flag ro, 2 CTRL: bit0 GIE rw,
//   bit1 IN_SERVICE ro, bits[4:2] active vector ro; 3 reads 0, writes ignored.
//   Unused bits read 0. Writes take effect the cycle after cfg_we.
//  Reset: MASK=0, GIE=0, state IDLE, cpu_irq=0, cpu_vec=0, irq_flag_clr=0, RR ptr=0.
//  Eligible set E = irq_flag & MASK & {NUM_IRQ{GIE}}.
//  FSM IDLE -> ASSERT -> SERVICE -> IDLE:
//  - IDLE: if E!=0, latch winner into cpu_vec, cpu_irq=1 next cycle, go ASSERT.
//    cpu_ack/cpu_iret ignored.
//  - ASSERT: hold cpu_irq, cpu_vec stable. On cpu_ack: next cycle cpu_irq=0,
//    irq_flag_clr[cpu_vec]=1 for exactly one cycle, go SERVICE.
//    Withdraw: if E[cpu_vec] drops (flag low, masked, GIE cleared) with no ack,
//    cpu_irq=0 next cycle, back to IDLE, no clear pulse. Ack and withdraw in same
//    cycle: ack wins. cpu_iret ignored.
//  - SERVICE: IN_SERVICE=1, no new request (no nesting), cpu_ack ignored. On
//    cpu_iret go IDLE; earliest new cpu_irq two cycles after cpu_iret.
//  Latency: E rising to cpu_irq = 1 cycle; cpu_ack to clr pulse = 1 cycle.
//  Flags re-asserting during SERVICE are held by the peripheral; serviced afterwards.
//  cfg write in same cycle as ack/iret: both take effect, no priority needed.
//  At most one bit of irq_flag_clr is ever high.
//  Reset asserted mid-operation: all state cleared at once, no clear pulse issued.
// CONFIGURATION
//  IRQ_RR_EN defined: round-robin arbitration. Search starts at RR ptr, wraps
//   NUM_IRQ-1 -> 0. On cpu_ack ptr <= (cpu_vec+1) mod NUM_IRQ.
//   CTRL bits[7:5] read ptr.
//  IRQ_RR_EN undefined: fixed priority, lowest index wins, no ptr. CTRL[7:5] read 0.
// TESTING
//  1 reset low with irq_flag=4'hF -> all outputs 0; after release, MASK=0,
//    so cpu_irq stays 0.
//  2 MASK=4'hF, GIE=1, irq_flag=4'b1010 -> cpu_irq=1, cpu_vec=1 one cycle later;
//    ack -> irq_flag_clr=4'b0010 for 1 cycle, CTRL[1]=1.
//  3 in SERVICE raise irq_flag[0] -> no cpu_irq until cpu_iret; then cpu_vec=0
//    two cycles after iret.
//  4 in ASSERT vec=2, write MASK=4'b1011 -> cpu_irq=0 next cycle, no clr pulse;
//    same cycle as cpu_ack -> clr[2] pulses.
//  5 IRQ_RR_EN, irq_flag=4'hF held, ack+iret loop -> vectors 0,1,2,3,0;
//    without macro -> 0,0,0,0.
//  6 cpu_ack in IDLE and cpu_iret in ASSERT -> no state change, no clr pulse.

Source files
------------

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//   Prioritising interrupt controller between the peripheral interrupt flags
//   and the CPU. The controller masks and arbitrates the sticky flags. It
//   presents one request plus its vector to the CPU. After the CPU acknowledges
//   the request, it sends a one-cycle clear pulse back to the winning
//   peripheral. The controller does not nest interrupts: the CPU must return
//   from the handler before a new request is raised.
//
// Configuration macro:
//   IRQ_RR_EN  defined   -> round-robin arbitration starting at a pointer.
//                           On each ack the pointer advances past the serviced
//                           source. CTRL[7:5] reads the pointer.
//              undefined -> fixed priority (lowest index wins).
//                           CTRL[7:5] reads 0.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   irq_flag      in   sticky level flags from peripherals
//   irq_flag_clr  out  one-cycle clear pulse to the serviced peripheral
//   cpu_irq       out  registered interrupt request to the CPU
//   cpu_vec       out  index of the requesting source (valid with cpu_irq)
//   cpu_ack       in   CPU has taken the request (one-cycle pulse)
//   cpu_iret      in   CPU has returned from the handler (one-cycle pulse)
//   cfg_we        in   register write strobe
//   cfg_addr      in   register select (0 MASK, 1 PENDING, 2 CTRL, 3 zero)
//   cfg_wdata     in   write data
//   cfg_rdata     out  read data, combinational from cfg_addr
// -----------------------------------------------------------------------------
module irq_controller #(
    parameter int NUM_IRQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IRQ-1:0]         irq_flag,
    output logic [NUM_IRQ-1:0]         irq_flag_clr,
    output logic                       cpu_irq,
    output logic [$clog2(NUM_IRQ)-1:0] cpu_vec,
    input  logic                       cpu_ack,
    input  logic                       cpu_iret,
    input  logic                       cfg_we,
    input  logic [1:0]                 cfg_addr,
    input  logic [7:0]                 cfg_wdata,
    output logic [7:0]                 cfg_rdata
);

    localparam int VEC_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_IRQ-1:0]   r_mask;
    logic                 r_gie;
    logic                 r_cpu_irq;
    logic                 w_irq_nxt;
    logic [VEC_W-1:0]     r_cpu_vec;
    logic [VEC_W-1:0]     w_vec_nxt;
    logic [NUM_IRQ-1:0]   r_clr;
    logic [NUM_IRQ-1:0]   w_clr_nxt;
    logic [NUM_IRQ-1:0]   w_elig;
    logic [VEC_W-1:0]     w_win;
    logic                 w_in_service;
    logic [7:0]           w_ctrl;
    logic [7:0]           w_rdata;
`ifdef IRQ_RR_EN
    logic [VEC_W-1:0]     r_rr_ptr;
    logic [VEC_W-1:0]     w_ptr_nxt;
`endif

    // Fixed priority: the scan runs from the top down, so the lowest set index is taken last and wins.
    function automatic logic [VEC_W-1:0] f_pick_fixed(input logic [NUM_IRQ-1:0] req);
        logic [VEC_W-1:0] win;
        win = {VEC_W{1'b0}};
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = VEC_W'(i);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

`ifdef IRQ_RR_EN
    // Round robin: take the first set request at or after the start index, wrapping around.
    function automatic logic [VEC_W-1:0] f_pick_rr(input logic [NUM_IRQ-1:0] req,
                                                   input logic [VEC_W-1:0]   start);
        logic [VEC_W-1:0] win;
        logic             found;
        int               idx;
        win   = {VEC_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_IRQ) begin
                idx = idx - NUM_IRQ;
            end else begin
                idx = idx;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = VEC_W'(idx);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction
`endif

    assign w_elig       = irq_flag & r_mask & {NUM_IRQ{r_gie}};
    assign w_in_service = (r_state == ST_SERVICE);

`ifdef IRQ_RR_EN
    assign w_win  = f_pick_rr(w_elig, r_rr_ptr);
    assign w_ctrl = 8'(r_gie) | (8'(w_in_service) << 1) | (8'(r_cpu_vec) << 2)
                  | (8'(r_rr_ptr) << 5);
`else
    assign w_win  = f_pick_fixed(w_elig);
    assign w_ctrl = 8'(r_gie) | (8'(w_in_service) << 1) | (8'(r_cpu_vec) << 2);
`endif

    // Configuration registers: MASK and GIE, written by the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= {NUM_IRQ{1'b0}};
            r_gie  <= 1'b0;
        end else if (cfg_we && (cfg_addr == 2'd0)) begin
            r_mask <= cfg_wdata[NUM_IRQ-1:0];
        end else if (cfg_we && (cfg_addr == 2'd2)) begin
            r_gie  <= cfg_wdata[0];
        end
    end

    // Next-state and next-output logic of the request/service sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = r_cpu_irq;
        w_vec_nxt   = r_cpu_vec;
        w_clr_nxt   = {NUM_IRQ{1'b0}};
`ifdef IRQ_RR_EN
        w_ptr_nxt   = r_rr_ptr;
`endif
        case (r_state)
            ST_IDLE: begin
                w_irq_nxt = 1'b0;
                if (|w_elig) begin
                    w_state_nxt = ST_ASSERT;
                    w_irq_nxt   = 1'b1;
                    w_vec_nxt   = w_win;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                // Ack has priority over withdraw, so a request taken in the same cycle is still cleared.
                if (cpu_ack) begin
                    w_state_nxt = ST_SERVICE;
                    w_irq_nxt   = 1'b0;
                    w_clr_nxt   = {{(NUM_IRQ-1){1'b0}}, 1'b1} << r_cpu_vec;
`ifdef IRQ_RR_EN
                    if (r_cpu_vec == VEC_W'(NUM_IRQ - 1)) begin
                        w_ptr_nxt = {VEC_W{1'b0}};
                    end else begin
                        w_ptr_nxt = r_cpu_vec + {{(VEC_W-1){1'b0}}, 1'b1};
                    end
`endif
                end else if (!w_elig[r_cpu_vec]) begin
                    w_state_nxt = ST_IDLE;
                    w_irq_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_SERVICE: begin
                w_irq_nxt = 1'b0;
                if (cpu_iret) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_irq_nxt   = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered CPU/peripheral outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cpu_irq <= 1'b0;
            r_cpu_vec <= {VEC_W{1'b0}};
            r_clr     <= {NUM_IRQ{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_cpu_irq <= w_irq_nxt;
            r_cpu_vec <= w_vec_nxt;
            r_clr     <= w_clr_nxt;
        end
    end

`ifdef IRQ_RR_EN
    // Round-robin search pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= {VEC_W{1'b0}};
        end else begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end
`endif

    // Register read mux.
    always_comb begin
        w_rdata = 8'h00;
        case (cfg_addr)
            2'd0:    w_rdata = 8'(r_mask);
            2'd1:    w_rdata = 8'(irq_flag);
            2'd2:    w_rdata = w_ctrl;
            default: w_rdata = 8'h00;
        endcase
    end

    assign cfg_rdata    = w_rdata;
    assign cpu_irq      = r_cpu_irq;
    assign cpu_vec      = r_cpu_vec;
    assign irq_flag_clr = r_clr;

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
//   Directed testbench for irq_controller (NUM_IRQ = 4).
//   Inputs are driven 1 time unit after the rising edge.
//   Outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_irq_controller;

    logic       clk;
    logic       reset;
    logic [3:0] irq_flag;
    logic [3:0] irq_flag_clr;
    logic       cpu_irq;
    logic [1:0] cpu_vec;
    logic       cpu_ack;
    logic       cpu_iret;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_vec [5];
    logic [3:0] one;

    irq_controller #(.NUM_IRQ(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_flag     (irq_flag),
        .irq_flag_clr (irq_flag_clr),
        .cpu_irq      (cpu_irq),
        .cpu_vec      (cpu_vec),
        .cpu_ack      (cpu_ack),
        .cpu_iret     (cpu_iret),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a);
        cfg_addr = a;
        #1;
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (!cpu_irq && n < 10) begin
            tick();
            n++;
        end
        check(tag, 32'(cpu_irq), 32'd1);
    endtask

    initial begin
        reset = 1'b0; irq_flag = 4'hF; cpu_ack = 1'b0; cpu_iret = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
        one = 4'b0001;
`ifdef IRQ_RR_EN
        exp_vec[0] = 2'd0; exp_vec[1] = 2'd1; exp_vec[2] = 2'd2; exp_vec[3] = 2'd3; exp_vec[4] = 2'd0;
`else
        exp_vec[0] = 2'd0; exp_vec[1] = 2'd0; exp_vec[2] = 2'd0; exp_vec[3] = 2'd0; exp_vec[4] = 2'd0;
`endif

        // 1: reset with all flags high
        repeat (3) tick();
        check("rst_irq", 32'(cpu_irq), 32'd0);
        check("rst_vec", 32'(cpu_vec), 32'd0);
        check("rst_clr", 32'(irq_flag_clr), 32'd0);
        reset = 1'b1;
        repeat (4) tick();
        check("idle_masked", 32'(cpu_irq), 32'd0);
        read_reg(2'd0); check("mask_rst", 32'(cfg_rdata), 32'h00);
        read_reg(2'd1); check("pending", 32'(cfg_rdata), 32'h0F);
        read_reg(2'd2); check("ctrl_rst", 32'(cfg_rdata), 32'h00);
        read_reg(2'd3); check("reg3", 32'(cfg_rdata), 32'h00);

        // 2: basic request/ack
        irq_flag = 4'b1010;
        cfg_write(2'd0, 8'h0F);
        cfg_write(2'd2, 8'h01);
        check("t2_lat0", 32'(cpu_irq), 32'd0);
        tick();
        check("t2_irq", 32'(cpu_irq), 32'd1);
        check("t2_vec", 32'(cpu_vec), 32'd1);
        read_reg(2'd2); check("t2_ctrl", 32'(cfg_rdata & 8'h1F), 32'h05);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("t2_ack_irq", 32'(cpu_irq), 32'd0);
        check("t2_clr", 32'(irq_flag_clr), 32'b0010);
        read_reg(2'd2); check("t2_insvc", 32'(cfg_rdata[1]), 32'd1);
`ifdef IRQ_RR_EN
        check("t2_ptr", 32'(cfg_rdata[7:5]), 32'd2);
`else
        check("t2_ctrl_hi", 32'(cfg_rdata[7:5]), 32'd0);
`endif
        irq_flag[1] = 1'b0;
        tick();
        check("t2_clr_once", 32'(irq_flag_clr), 32'd0);

        // 3: no nesting during service
        irq_flag = 4'b1001;
        repeat (3) tick();
        check("t3_hold", 32'(cpu_irq), 32'd0);
        cpu_iret = 1'b1; tick(); cpu_iret = 1'b0;
        check("t3_iret1", 32'(cpu_irq), 32'd0);
        tick();
        check("t3_irq", 32'(cpu_irq), 32'd1);
`ifdef IRQ_RR_EN
        check("t3_vec", 32'(cpu_vec), 32'd3);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("t3_clr", 32'(irq_flag_clr), 32'b1000);
`else
        check("t3_vec", 32'(cpu_vec), 32'd0);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("t3_clr", 32'(irq_flag_clr), 32'b0001);
`endif
        irq_flag = 4'b0000;
        cpu_iret = 1'b1; tick(); cpu_iret = 1'b0;
        repeat (2) tick();
        check("t3_idle", 32'(cpu_irq), 32'd0);

        // 4: withdraw by masking, then mask write together with ack
        irq_flag = 4'b0100;
        tick();
        check("t4_irq", 32'(cpu_irq), 32'd1);
        check("t4_vec", 32'(cpu_vec), 32'd2);
        cfg_write(2'd0, 8'h0B);
        check("t4_still", 32'(cpu_irq), 32'd1);
        tick();
        check("t4_wd_irq", 32'(cpu_irq), 32'd0);
        check("t4_wd_clr", 32'(irq_flag_clr), 32'd0);
        tick();
        check("t4_wd_clr2", 32'(irq_flag_clr), 32'd0);
        read_reg(2'd2); check("t4_wd_svc", 32'(cfg_rdata[1]), 32'd0);
        cfg_write(2'd0, 8'h0F);
        tick();
        check("t4_re_irq", 32'(cpu_irq), 32'd1);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'h0B; cpu_ack = 1'b1;
        tick();
        cfg_we = 1'b0; cpu_ack = 1'b0;
        check("t4_ack_clr", 32'(irq_flag_clr), 32'b0100);
        check("t4_ack_irq", 32'(cpu_irq), 32'd0);
        irq_flag = 4'b0000;
        cpu_iret = 1'b1; tick(); cpu_iret = 1'b0;

        // Reset mid-operation
        irq_flag = 4'hF;
        tick();
        check("mo_irq", 32'(cpu_irq), 32'd1);
        reset = 1'b0;
        #1;
        check("mo_rst_irq", 32'(cpu_irq), 32'd0);
        check("mo_rst_vec", 32'(cpu_vec), 32'd0);
        check("mo_rst_clr", 32'(irq_flag_clr), 32'd0);
        read_reg(2'd0); check("mo_rst_mask", 32'(cfg_rdata), 32'h00);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // 5: arbitration sequence with all flags held
        cfg_write(2'd0, 8'h0F);
        cfg_write(2'd2, 8'h01);
        for (int k = 0; k < 5; k++) begin
            wait_irq("t5_irq");
            check("t5_vec", 32'(cpu_vec), 32'(exp_vec[k]));
            cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
            check("t5_clr", 32'(irq_flag_clr), 32'(one << exp_vec[k]));
            cpu_iret = 1'b1; tick(); cpu_iret = 1'b0;
        end

        // 6: ack in IDLE, iret in ASSERT
        irq_flag = 4'b0000;
        tick();
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("t6_ack_irq", 32'(cpu_irq), 32'd0);
        check("t6_ack_clr", 32'(irq_flag_clr), 32'd0);
        read_reg(2'd2); check("t6_ack_svc", 32'(cfg_rdata[1]), 32'd0);
        tick();
        check("t6_ack_clr2", 32'(irq_flag_clr), 32'd0);
        irq_flag = 4'b1000;
        tick();
        check("t6_irq", 32'(cpu_irq), 32'd1);
        check("t6_vec", 32'(cpu_vec), 32'd3);
        cpu_iret = 1'b1; tick(); cpu_iret = 1'b0;
        check("t6_iret_irq", 32'(cpu_irq), 32'd1);
        check("t6_iret_clr", 32'(irq_flag_clr), 32'd0);
        check("t6_iret_vec", 32'(cpu_vec), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
